// File: rtl/nco_poly.sv
// Polyphonic time-multiplexed NCO: one voice per clock is stepped and
// mixed into a sample produced once per sample tick.
module nco_poly #(
   parameter int VOICES     = 4,
   parameter int PHASE_W    = 16,
   parameter int OUT_W      = 8,
   parameter int SAMPLE_DIV = 3125
) (
   input  logic                                    i_clk,
   input  logic                                    i_rst_n,
   input  logic                                    i_wr_en,
   input  logic [((VOICES > 1) ? $clog2(VOICES) : 1)-1:0] i_voice_sel,
   input  logic                                    i_gate,
   input  logic [1:0]                              i_wave,
   input  logic [PHASE_W-1:0]                      i_step,
   input  logic                                    i_key_sync,
   output logic [OUT_W-1:0]                        o_sample_out,
   output logic                                    o_sample_valid,
   output logic                                    o_overrun
);

   localparam int LV = $clog2(VOICES);
   localparam int VW = (VOICES > 1) ? LV : 1;
   localparam int AW = OUT_W + LV;
   localparam int CW = $clog2(SAMPLE_DIV);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_OUT
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CW-1:0]        r_cnt;
   logic [VW-1:0]        r_v;
   logic [AW-1:0]        r_acc;
   logic [PHASE_W-1:0]   r_phase [VOICES];
   logic [PHASE_W-1:0]   r_step  [VOICES];
   logic [1:0]           r_wave  [VOICES];
   logic                 r_gate  [VOICES];
   logic [OUT_W-1:0]     r_sample;
   logic                 r_valid;
   logic                 r_overrun;

   logic                 w_tick;
   logic                 w_last;
   logic [PHASE_W-1:0]   w_p;
   logic [OUT_W-1:0]     w_tri;
   logic [OUT_W-1:0]     w_wv;
   logic [AW-1:0]        w_sum;

   assign w_tick = (r_cnt == CW'(SAMPLE_DIV - 1));
   assign w_last = (r_v == VW'(VOICES - 1));

   // wave value of the voice under processing, from its pre-update phase
   always_comb begin
      w_p   = r_phase[r_v];
      w_tri = w_p[PHASE_W-2 -: OUT_W];
      w_wv  = '0;
      if (r_gate[r_v]) begin
         unique case (r_wave[r_v])
            2'd0:    w_wv = w_p[PHASE_W-1 -: OUT_W];
            2'd1:    w_wv = {OUT_W{w_p[PHASE_W-1]}};
            2'd2:    w_wv = w_p[PHASE_W-1] ? ~w_tri : w_tri;
            default: w_wv = '0;
         endcase
      end
      w_sum = r_acc + AW'(w_wv);
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (w_tick) w_state_nxt = S_ACCUM;
         S_ACCUM: if (w_last) w_state_nxt = S_OUT;
         S_OUT:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_v       <= '0;
         r_acc     <= '0;
         r_sample  <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
         for (int i = 0; i < VOICES; i++) begin
            r_phase[i] <= '0;
            r_step[i]  <= '0;
            r_wave[i]  <= '0;
            r_gate[i]  <= 1'b0;
         end
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_tick ? '0 : r_cnt + CW'(1);
         r_valid <= 1'b0;
         if (w_tick && r_state != S_IDLE)
            r_overrun <= 1'b1;
         if (r_state == S_IDLE && w_tick) begin
            r_v   <= '0;
            r_acc <= '0;
         end
         if (r_state == S_ACCUM) begin
            r_acc <= w_sum;
            r_v   <= r_v + VW'(1);
            if (r_gate[r_v])
               r_phase[r_v] <= r_phase[r_v] + r_step[r_v];
            // result is visible in the OUT cycle together with the pulse
            if (w_last) begin
               r_sample <= w_sum[LV +: OUT_W];
               r_valid  <= 1'b1;
            end
         end
         // host write last so key sync wins over the phase step
         if (i_wr_en) begin
            r_gate[i_voice_sel] <= i_gate;
            r_wave[i_voice_sel] <= i_wave;
            r_step[i_voice_sel] <= i_step;
            if (i_key_sync)
               r_phase[i_voice_sel] <= '0;
         end
      end
   end

   assign o_sample_out   = r_sample;
   assign o_sample_valid = r_valid;
   assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_nco_poly.sv
// Directed bench for nco_poly: table of voice setups with expected
// sample sequences, plus latency, wrap, key-sync and reset sequences.
module tb_nco_poly;

   logic        clk;
   logic        rst_n;
   logic        wr_en;
   logic [1:0]  voice_sel;
   logic        gate;
   logic [1:0]  wave;
   logic [15:0] step;
   logic        key_sync;
   logic [7:0]  sample_out;
   logic        sample_valid;
   logic        overrun;

   int n_checks;
   int n_errors;

   nco_poly #(
      .VOICES(4),
      .PHASE_W(16),
      .OUT_W(8),
      .SAMPLE_DIV(8)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_wr_en(wr_en),
      .i_voice_sel(voice_sel),
      .i_gate(gate),
      .i_wave(wave),
      .i_step(step),
      .i_key_sync(key_sync),
      .o_sample_out(sample_out),
      .o_sample_valid(sample_valid),
      .o_overrun(overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  gate;
      logic [7:0]  wave;
      logic [63:0] step;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_sample", 32'(sample_out), 32'h0);
      check("rst_valid", 32'(sample_valid), 32'h0);
      check("rst_overrun", 32'(overrun), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wr(input int v, input logic g, input logic [1:0] w,
                     input logic [15:0] s, input logic ks);
      voice_sel = 2'(v);
      gate      = g;
      wave      = w;
      step      = s;
      key_sync  = ks;
      wr_en     = 1'b1;
      @(negedge clk);
      wr_en     = 1'b0;
      key_sync  = 1'b0;
   endtask

   task automatic wait_valid(output logic [7:0] s, output int cyc);
      s   = '0;
      cyc = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (sample_valid) begin
            s   = sample_out;
            cyc = k;
            return;
         end
      end
      n_checks++;
      n_errors++;
      $display("FAIL valid_timeout: got no pulse expected pulse within 40");
   endtask

   logic [7:0] s;
   int         cyc;

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b1;
      wr_en = 1'b0;
      voice_sel = '0;
      gate = 1'b0;
      wave = '0;
      step = '0;
      key_sync = 1'b0;

      vecs[0] = '{4'b0000, 8'h00, 64'h0, 32'h0000_0000};
      vecs[1] = '{4'b1111, 8'h00, {4{16'h0100}}, 32'h0302_0100};
      vecs[2] = '{4'b1111, 8'h55, {4{16'h8000}}, 32'hFF00_FF00};
      vecs[3] = '{4'b0001, 8'h02, 64'h0000_0000_0000_4000,
                  32'h1F3F_2000};
      vecs[4] = '{4'b1111, 8'hE4, 64'h1234_2000_4000_1000,
                  32'h7B67_1400};
      vecs[5] = '{4'b0000, 8'h55, {4{16'h8000}}, 32'h0000_0000};
      vecs[6] = '{4'b1111, 8'h00, {4{16'hC000}}, 32'h4080_C000};

      // idle after reset: latency, period, one-cycle pulse
      do_reset();
      wait_valid(s, cyc);
      check("first_latency", 32'(cyc), 32'd12);
      check("idle_sample0", 32'(s), 32'h0);
      wait_valid(s, cyc);
      check("idle_period", 32'(cyc), 32'd8);
      check("idle_sample1", 32'(s), 32'h0);
      @(negedge clk);
      check("valid_one_cycle", 32'(sample_valid), 32'h0);
      check("hold_sample", 32'(sample_out), 32'h0);

      for (int i = 0; i < 7; i++) begin
         do_reset();
         for (int v = 0; v < 4; v++)
            wr(v, vecs[i].gate[v], vecs[i].wave[2*v +: 2],
               vecs[i].step[16*v +: 16], 1'b0);
         for (int k = 0; k < 4; k++) begin
            wait_valid(s, cyc);
            check($sformatf("vec%0d_s%0d", i, k), 32'(s),
                  32'(vecs[i].exp[8*k +: 8]));
         end
      end

      // phase wrap FF00 -> 0000 over 256 ticks
      do_reset();
      for (int v = 0; v < 4; v++) wr(v, 1'b1, 2'd0, 16'h0100, 1'b0);
      for (int k = 0; k < 258; k++) begin
         wait_valid(s, cyc);
         check($sformatf("wrap_s%0d", k), 32'(s), 32'(k & 255));
      end

      // key sync on voice 2 during its own accumulate cycle
      do_reset();
      wr(2, 1'b1, 2'd0, 16'h4000, 1'b0);
      wait_valid(s, cyc);
      check("ks_p1", 32'(s), 32'h00);
      wait_valid(s, cyc);
      check("ks_p2", 32'(s), 32'h10);
      repeat (6) @(negedge clk);
      wr(2, 1'b1, 2'd0, 16'h4000, 1'b1);
      wait_valid(s, cyc);
      check("ks_p3_old", 32'(s), 32'h20);
      wait_valid(s, cyc);
      check("ks_p4_zero", 32'(s), 32'h00);
      wait_valid(s, cyc);
      check("ks_p5", 32'(s), 32'h10);

      // reset during the voice-1 accumulate cycle
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_sample", 32'(sample_out), 32'h0);
      check("midrst_valid", 32'(sample_valid), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_valid(s, cyc);
      check("midrst_latency", 32'(cyc), 32'd12);
      check("midrst_sample_after", 32'(s), 32'h0);
      check("overrun_end", 32'(overrun), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
